// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one single-port RAM.
// MEM requests win over IF requests; each access lasts WAIT_CYCLES+1 cycles and ends with a one-cycle ack.
module mem_port_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_ACC  = 2'd1,
        MEM_ACC = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_if_ack;
    logic              r_mem_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              w_mem_req;
    logic              w_grant_mem;
    logic              w_grant_if;
    logic              w_done;

    assign w_mem_req = mem_rd | mem_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An ack still high in IDLE means its requester has not yet seen completion: grant nothing.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_mem = 1'b0;
        w_grant_if  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_if_ack && !r_mem_ack) begin
                    if (w_mem_req) begin
                        w_grant_mem = 1'b1;
                        w_state_nxt = MEM_ACC;
                    end else if (if_req) begin
                        w_grant_if  = 1'b1;
                        w_state_nxt = IF_ACC;
                    end
                end
            end
            IF_ACC, MEM_ACC: begin
                if (r_cnt == WAIT_LAST) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Access datapath: latch the winner on grant, count wait cycles, capture and ack on the final edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;
            if (w_grant_mem) begin
                r_cnt       <= '0;
                r_ram_en    <= 1'b1;
                r_ram_we    <= mem_wr;
                r_ram_addr  <= mem_addr;
                r_ram_wdata <= mem_wdata;
            end else if (w_grant_if) begin
                r_cnt      <= '0;
                r_ram_en   <= 1'b1;
                r_ram_we   <= 1'b0;
                r_ram_addr <= if_addr;
            end else if (w_done) begin
                r_ram_en <= 1'b0;
                r_ram_we <= 1'b0;
                if (r_state == MEM_ACC) begin
                    r_mem_ack <= 1'b1;
                    if (!r_ram_we) begin
                        r_mem_rdata <= ram_rdata;
                    end
                end else begin
                    r_if_ack   <= 1'b1;
                    r_if_rdata <= ram_rdata;
                end
            end else if (r_state != IDLE) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign if_ack    = r_if_ack;
    assign mem_ack   = r_mem_ack;
    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign stall_if  = if_req & ~r_if_ack;
    assign stall_mem = w_mem_req & ~r_mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: WAIT_CYCLES=1 main instance plus a WAIT_CYCLES=0 instance.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
    logic        if_ack, mem_ack, ram_en, ram_we, stall_if, stall_mem;

    logic        z_if_req = 1'b0;
    logic [31:0] z_if_addr = '0;
    logic [31:0] z_if_rdata, z_mem_rdata, z_ram_addr, z_ram_wdata, z_ram_rdata;
    logic        z_if_ack, z_mem_ack, z_ram_en, z_ram_we, z_stall_if, z_stall_mem;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_mem_acks = 0;
    logic [31:0] q_if[$];
    logic [31:0] q_mem[$];
    logic [31:0] exp_mem_rdata = '0;
    logic [31:0] exp_st_addr = '0, exp_st_data = '0;
    logic        prev_if_ack = 1'b0, prev_mem_ack = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_model(input logic [31:0] a);
        return (a == 32'h40) ? 32'h0000_1234 : ((a ^ 32'h5A5A_0000) + 32'h11);
    endfunction

    assign ram_rdata   = ram_model(ram_addr);
    assign z_ram_rdata = ram_model(z_ram_addr);

    mem_port_arbiter #(.WAIT_CYCLES(1), .ADDR_W(32), .DATA_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    mem_port_arbiter #(.WAIT_CYCLES(0), .ADDR_W(32), .DATA_W(32)) u_dut_w0 (
        .clk(clk), .rst(rst),
        .if_req(z_if_req), .if_addr(z_if_addr), .if_rdata(z_if_rdata), .if_ack(z_if_ack),
        .mem_rd(1'b0), .mem_wr(1'b0), .mem_addr(32'h0), .mem_wdata(32'h0),
        .mem_rdata(z_mem_rdata), .mem_ack(z_mem_ack),
        .ram_en(z_ram_en), .ram_we(z_ram_we), .ram_addr(z_ram_addr), .ram_wdata(z_ram_wdata),
        .ram_rdata(z_ram_rdata), .stall_if(z_stall_if), .stall_mem(z_stall_mem)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops an expected word on every ack and checks store cycles on the RAM side.
    always @(negedge clk) begin
        if (!rst) begin
            if (if_ack) begin
                check("if_ack_width", 64'(prev_if_ack), 64'd0);
                if (q_if.size() == 0) check("if_ack_unexpected", 64'd1, 64'd0);
                else check("if_rdata", 64'(if_rdata), 64'(q_if.pop_front()));
            end
            if (mem_ack) begin
                n_mem_acks++;
                check("mem_ack_width", 64'(prev_mem_ack), 64'd0);
                if (q_mem.size() == 0) check("mem_ack_unexpected", 64'd1, 64'd0);
                else check("mem_rdata", 64'(mem_rdata), 64'(q_mem.pop_front()));
            end
            if (ram_en && ram_we) begin
                check("st_addr", 64'(ram_addr), 64'(exp_st_addr));
                check("st_wdata", 64'(ram_wdata), 64'(exp_st_data));
            end
        end
        prev_if_ack  <= if_ack;
        prev_mem_ack <= mem_ack;
    end

    task automatic wait_ack(input bit is_mem, output int lat, output int en_cyc, output int we_cyc);
        lat = 0; en_cyc = 0; we_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (ram_en) en_cyc++;
            if (ram_en && ram_we) we_cyc++;
            if (is_mem ? mem_ack : if_ack) return;
        end
        check(is_mem ? "mem_ack_timeout" : "if_ack_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int lat, en_c, we_c, base, last, n_z;

        repeat (2) @(negedge clk);
        check("rst_ram_en", 64'(ram_en), 64'd0);
        check("rst_ram_addr", 64'(ram_addr), 64'd0);
        check("rst_acks", 64'({if_ack, mem_ack}), 64'd0);
        check("rst_rdata", {if_rdata, mem_rdata}, 64'd0);
        rst = 1'b0;

        // Single fetch
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40; q_if.push_back(32'h1234);
        wait_ack(1'b0, lat, en_c, we_c);
        check("if_latency", 64'(lat), 64'd3);
        check("if_en_cycles", 64'(en_c), 64'd2);
        check("if_stall_at_ack", 64'(stall_if), 64'd0);
        if_req = 1'b0;

        // Simultaneous load and fetch: MEM wins, IF follows after the mem_ack cycle
        @(negedge clk);
        mem_rd = 1'b1; mem_addr = 32'h100; if_req = 1'b1; if_addr = 32'h80;
        exp_mem_rdata = ram_model(32'h100);
        q_mem.push_back(exp_mem_rdata); q_if.push_back(ram_model(32'h80));
        @(negedge clk);
        check("prio_addr", 64'(ram_addr), 64'h100);
        check("prio_stalls", 64'({ram_en, ram_we, stall_mem, stall_if}), 64'b1011);
        wait_ack(1'b1, lat, en_c, we_c);
        check("prio_lat", 64'(lat), 64'd2);
        check("prio_no_if_ack", 64'(if_ack), 64'd0);
        mem_rd = 1'b0;
        @(negedge clk);
        check("prio_gap", 64'(ram_en), 64'd0);
        @(negedge clk);
        check("prio_if_grant", 64'({ram_en, ram_we, ram_addr}), {32'h0, 2'b10, 32'h80});
        wait_ack(1'b0, lat, en_c, we_c);
        if_req = 1'b0;

        // Store leaves mem_rdata untouched
        @(negedge clk);
        mem_wr = 1'b1; mem_addr = 32'h200; mem_wdata = 32'hDEAD_BEEF;
        exp_st_addr = 32'h200; exp_st_data = 32'hDEAD_BEEF; q_mem.push_back(exp_mem_rdata);
        wait_ack(1'b1, lat, en_c, we_c);
        check("st_we_cycles", 64'(we_c), 64'd2);
        mem_wr = 1'b0;

        // rd and wr together act as a single store
        @(negedge clk);
        base = n_mem_acks;
        mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 32'h300; mem_wdata = 32'hCAFE_F00D;
        exp_st_addr = 32'h300; exp_st_data = 32'hCAFE_F00D; q_mem.push_back(exp_mem_rdata);
        wait_ack(1'b1, lat, en_c, we_c);
        check("rdwr_we_cycles", 64'(we_c), 64'd2);
        mem_rd = 1'b0; mem_wr = 1'b0;
        repeat (3) @(negedge clk);
        check("rdwr_single_ack", 64'(n_mem_acks - base), 64'd1);

        // Request dropped after its first access cycle still completes
        if_req = 1'b1; if_addr = 32'h48; q_if.push_back(ram_model(32'h48));
        @(negedge clk);
        if_req = 1'b0;
        wait_ack(1'b0, lat, en_c, we_c);
        check("drop_lat", 64'(lat), 64'd2);

        // Asynchronous reset in the second MEM_ACC cycle
        @(negedge clk);
        base = n_mem_acks;
        mem_rd = 1'b1; mem_addr = 32'h400;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_acks_en", 64'({if_ack, mem_ack, ram_en, ram_we}), 64'd0);
        check("arst_addr_wdata", {ram_addr, ram_wdata}, 64'd0);
        check("arst_rdata", {if_rdata, mem_rdata}, 64'd0);
        @(negedge clk);
        rst = 1'b0; mem_rd = 1'b0; exp_mem_rdata = '0;
        if_req = 1'b1; if_addr = 32'h44; q_if.push_back(ram_model(32'h44));
        @(negedge clk);
        check("post_rst_grant", 64'({ram_en, ram_addr}), {31'h0, 1'b1, 32'h44});
        wait_ack(1'b0, lat, en_c, we_c);
        if_req = 1'b0;
        repeat (3) @(negedge clk);
        check("arst_no_mem_ack", 64'(n_mem_acks - base), 64'd0);

        // WAIT_CYCLES=0 with fetch held high: one ack every 3 cycles
        z_if_req = 1'b1; z_if_addr = 32'h60;
        last = -1; n_z = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (z_if_ack) begin
                n_z++;
                check("w0_rdata", 64'(z_if_rdata), 64'(ram_model(32'h60)));
                if (last >= 0) check("w0_period", 64'(i - last), 64'd3);
                last = i;
            end
        end
        check("w0_ack_count", 64'(n_z >= 6), 64'd1);
        z_if_req = 1'b0;

        repeat (2) @(negedge clk);
        check("q_if_empty", 64'(q_if.size()), 64'd0);
        check("q_mem_empty", 64'(q_mem.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, default 1, extra RAM latency cycles per access (range 0..15).
REQ-002 Parameter: ADDR_W, default 32, address width.
REQ-003 Parameter: DATA_W, default 32, data width.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 if_req  input  1  instruction-fetch read request; held until if_ack.
REQ-007 if_addr  input  ADDR_W  fetch address.
REQ-008 if_rdata  output  DATA_W  fetched word, registered.
REQ-009 if_ack  output  1  one-cycle fetch completion pulse, registered.
REQ-010 mem_rd  input  1  MEM-stage load request; held until mem_ack.
REQ-011 mem_wr  input  1  MEM-stage store request; held until mem_ack.
REQ-012 mem_addr  input  ADDR_W  load/store address.
REQ-013 mem_wdata  input  DATA_W  store data.
REQ-014 mem_rdata  output  DATA_W  load data, registered.
REQ-015 mem_ack  output  1  one-cycle load/store completion pulse, registered.
REQ-016 ram_en  output  1  single-port RAM enable.
REQ-017 ram_we  output  1  RAM write enable.
REQ-018 ram_addr  output  ADDR_W  RAM address.
REQ-019 ram_wdata  output  DATA_W  RAM write data.
REQ-020 ram_rdata  input  DATA_W  RAM read data, valid while ram_en high and ram_we low.
REQ-021 stall_if  output  1  holds PC and IF/ID register: if_req & ~if_ack.
REQ-022 stall_mem  output  1  holds whole pipeline: (mem_rd | mem_wr) & ~mem_ack.

Function
REQ-023 FSM states SHALL be IDLE, IF_ACC, MEM_ACC.
REQ-024 IDLE with both ack outputs low: mem_rd|mem_wr -> MEM_ACC; else if_req -> IF_ACC; else stay.
REQ-025 MEM requests SHALL have fixed priority over IF requests.
REQ-026 IDLE with either ack high SHALL ignore all requests that cycle (no stale re-grant).
REQ-027 On grant, ram_addr/ram_wdata/ram_we SHALL be latched from the winning requester and held constant for the whole access.
REQ-028 In IF_ACC/MEM_ACC: ram_en=1; ram_we=1 only for MEM_ACC store; IDLE: ram_en=0, ram_we=0.
REQ-029 A 4-bit wait counter SHALL clear on grant, increment each ACC cycle, and end the access when equal to WAIT_CYCLES; each ACC state lasts WAIT_CYCLES+1 cycles.
REQ-030 On the final ACC edge: read data SHALL be captured from ram_rdata into if_rdata or mem_rdata, the matching ack SHALL set, and state SHALL return to IDLE.
REQ-031 Ack SHALL be high exactly one cycle; rdata registers SHALL hold until the next capture.
REQ-032 Store completion SHALL NOT modify mem_rdata.
REQ-033 mem_rd and mem_wr both high: treated as store, no read capture.
REQ-034 Request dropped mid-access: access SHALL complete and ack SHALL still pulse.
REQ-035 Latency: request seen in IDLE at edge k -> ack high in cycle following edge k+WAIT_CYCLES+1; minimum back-to-back period WAIT_CYCLES+3 cycles.
REQ-036 if_req arriving during MEM_ACC SHALL be granted only after mem_ack cycle, if no MEM request is pending.

Reset
REQ-037 rst high SHALL immediately force IDLE, counter=0, if_ack=0, mem_ack=0, if_rdata=0, mem_rdata=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, regardless of clock.
REQ-038 Reset mid-access SHALL abort the access with no ack after release; first grant possible on first rising edge with rst low.

Verification
REQ-039 WAIT_CYCLES=1, if_req, if_addr=0x40, ram_rdata=0x1234 -> ram_en high 2 cycles, if_ack 1 cycle, if_rdata=0x1234, stall_if low after ack.
REQ-040 if_req and mem_rd together, mem_addr=0x100 -> MEM_ACC first, mem_ack before if_ack, IF access starts after mem_ack cycle.
REQ-041 mem_wr, mem_addr=0x200, mem_wdata=0xDEADBEEF -> ram_we=1 with those values for 2 cycles, mem_ack pulse, mem_rdata unchanged.
REQ-042 WAIT_CYCLES=0, continuous if_req -> ack every 3 cycles, no stale double grant.
REQ-043 rst asserted asynchronously in 2nd MEM_ACC cycle -> all outputs 0 at once, no mem_ack after release.
REQ-044 mem_rd and mem_wr both high -> store performed, mem_rdata unchanged, single mem_ack.
